// File: rtl/befehl_abruf_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Width defaults, the fetch state encoding and the all-ones address.
package befehl_abruf_pkg;

  localparam int ADRESS_BREITE_STD = 26;
  localparam int DATEN_BREITE_STD  = 32;

  // The PC's +1 turns this into address 0, so a jump to 0 writes this value.
  localparam logic [ADRESS_BREITE_STD-1:0] ALLE_EINSEN = '1;

  typedef enum logic [2:0] {
    LEERLAUF,
    ANFRAGE,
    HALTEN,
    SPRUNG,
    ABWARTEN
  } zustand_t;

endpackage

// File: rtl/befehl_abruf.sv
// Instruction-fetch controller: one memory read per instruction, holds the word
// for decode, and redirects the external program counter on jump requests.
module befehl_abruf
  import befehl_abruf_pkg::*;
#(
  parameter int ADRESS_BREITE = ADRESS_BREITE_STD,
  parameter int DATEN_BREITE  = DATEN_BREITE_STD
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [ADRESS_BREITE-1:0] AktuellerPC,
  output logic [ADRESS_BREITE-1:0] NeuerPC,
  output logic                     SchreibSignal,
  output logic                     TaktSignal,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic                     SpeicherLesen,
  input  logic                     SpeicherBereit,
  input  logic [DATEN_BREITE-1:0]  SpeicherDaten,
  output logic [DATEN_BREITE-1:0]  Befehl,
  output logic                     BefehlGueltig,
  input  logic                     BefehlAngenommen,
  input  logic                     Sprung,
  input  logic [ADRESS_BREITE-1:0] SprungZiel
);

  zustand_t                 zustand, zustand_next;
  logic [ADRESS_BREITE-1:0] neuer_pc_next;
  logic                     schreib_next;
  logic                     takt_next;
  logic [ADRESS_BREITE-1:0] adresse_next;
  logic                     lesen_next;
  logic [DATEN_BREITE-1:0]  befehl_next;
  logic                     gueltig_next;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    zustand_next  = zustand;
    neuer_pc_next = NeuerPC;
    schreib_next  = 1'b0;
    takt_next     = 1'b0;
    adresse_next  = SpeicherAdresse;
    lesen_next    = SpeicherLesen;
    befehl_next   = Befehl;
    gueltig_next  = BefehlGueltig;

    if (Sprung) begin
      // The PC loads NeuerPC+1, so write the target minus one (wrapping).
      neuer_pc_next = SprungZiel - ADRESS_BREITE'(1);
      schreib_next  = 1'b1;
      takt_next     = 1'b1;
      gueltig_next  = 1'b0;
      if ((zustand == ANFRAGE || zustand == ABWARTEN) && !SpeicherBereit) begin
        zustand_next = ABWARTEN;
      end else begin
        zustand_next = SPRUNG;
        lesen_next   = 1'b0;
      end
    end else begin
      unique case (zustand)
        LEERLAUF: begin
          adresse_next = AktuellerPC;
          lesen_next   = 1'b1;
          zustand_next = ANFRAGE;
        end
        ANFRAGE: begin
          if (SpeicherBereit) begin
            befehl_next  = SpeicherDaten;
            gueltig_next = 1'b1;
            lesen_next   = 1'b0;
            takt_next    = 1'b1;
            zustand_next = HALTEN;
          end
        end
        HALTEN: begin
          if (BefehlAngenommen) begin
            gueltig_next = 1'b0;
            zustand_next = LEERLAUF;
          end
        end
        SPRUNG: begin
          zustand_next = LEERLAUF;
        end
        ABWARTEN: begin
          // Data of the abandoned read is dropped without stepping the PC.
          if (SpeicherBereit) begin
            lesen_next   = 1'b0;
            zustand_next = LEERLAUF;
          end
        end
        default: begin
          zustand_next = LEERLAUF;
        end
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; reset here is synchronous and wins over every request.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand         <= LEERLAUF;
      NeuerPC         <= '0;
      SchreibSignal   <= 1'b0;
      TaktSignal      <= 1'b0;
      SpeicherAdresse <= '0;
      SpeicherLesen   <= 1'b0;
      Befehl          <= '0;
      BefehlGueltig   <= 1'b0;
    end else begin
      zustand         <= zustand_next;
      NeuerPC         <= neuer_pc_next;
      SchreibSignal   <= schreib_next;
      TaktSignal      <= takt_next;
      SpeicherAdresse <= adresse_next;
      SpeicherLesen   <= lesen_next;
      Befehl          <= befehl_next;
      BefehlGueltig   <= gueltig_next;
    end
  end

endmodule

// File: doc/befehl_abruf.md
Name: befehl_abruf

Overview:
Instruction-fetch controller that drives the program counter's control inputs (NeuerPC, SchreibSignal, TaktSignal) and reads instructions at AktuellerPC.
- Sits between the program counter, instruction memory and the decode stage.
- Issues one memory read per instruction.
- Holds the fetched word until decode accepts it.
- Redirects the PC on jump requests.

Parameters:
ADRESS_BREITE, 26, width of PC and memory address
DATEN_BREITE, 32, instruction word width

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
AktuellerPC  in  ADRESS_BREITE  current PC value from program counter
NeuerPC  out  ADRESS_BREITE  PC write value (program counter loads NeuerPC+1)
SchreibSignal  out  1  PC load select
TaktSignal  out  1  PC step enable, one-cycle pulses
SpeicherAdresse  out  ADRESS_BREITE  instruction memory read address
SpeicherLesen  out  1  read request, held until SpeicherBereit
SpeicherBereit  in  1  read data valid; sampled only while SpeicherLesen=1
SpeicherDaten  in  DATEN_BREITE  read data
Befehl  out  DATEN_BREITE  fetched instruction
BefehlGueltig  out  1  Befehl valid
BefehlAngenommen  in  1  decode accepts Befehl
Sprung  in  1  jump request, single-cycle
SprungZiel  in  ADRESS_BREITE  jump target address

Behaviour:
- One clock; reset is synchronous and active-high on Clock/Reset. All outputs are registered.
- Reset value of every output is 0, and the state is LEERLAUF. Reset has priority over everything, including mid-request: SpeicherLesen drops the next cycle.
- Priority: Reset > Sprung > SpeicherBereit/BefehlAngenommen.
- States: LEERLAUF, ANFRAGE, HALTEN, SPRUNG, ABWARTEN.
- LEERLAUF (exactly 1 cycle, no Sprung): latch AdresseReg<=AktuellerPC, set SpeicherLesen<=1, go to ANFRAGE.
- ANFRAGE:
  - SpeicherAdresse=AdresseReg, stable while SpeicherLesen=1.
  - On SpeicherBereit: Befehl<=SpeicherDaten, BefehlGueltig<=1, SpeicherLesen<=0, TaktSignal<=1 (SchreibSignal=0), go to HALTEN.
- HALTEN:
  - TaktSignal is 1 only in the first cycle.
  - Befehl and BefehlGueltig stay stable until BefehlAngenommen=1. Then BefehlGueltig<=0 and go to LEERLAUF.
  - Accept in the first HALTEN cycle is legal; the PC has updated by LEERLAUF.
- Sprung, in any state:
  - Next cycle drive NeuerPC=SprungZiel-1 (mod 2^ADRESS_BREITE), SchreibSignal=1, TaktSignal=1 for exactly one cycle. The PC then holds SprungZiel.
  - BefehlGueltig<=0 next cycle; the held instruction is discarded, even if BefehlAngenommen is high in the same cycle.
  - If a read is outstanding after this cycle (ANFRAGE without SpeicherBereit, or ABWARTEN), go to ABWARTEN; otherwise go to SPRUNG.
  - Sprung coinciding with SpeicherBereit: data dropped, no increment pulse, only the write pulse.
- SPRUNG: one cycle, then go to LEERLAUF.
- ABWARTEN:
  - SpeicherLesen stays 1 with the old address until SpeicherBereit.
  - Returned data is dropped; no TaktSignal increment.
  - Then go to LEERLAUF, never before the write pulse cycle has elapsed.
- A new Sprung in SPRUNG or ABWARTEN overrides the target: new write pulse, state per the rule above.
- Sprung during the HALTEN increment-pulse cycle: increment occurs, write pulse follows; final PC=SprungZiel.
- Wrap-around: SprungZiel=0 gives NeuerPC=all ones; the PC's +1 wraps to 0. Fetch addresses wrap identically.
- TaktSignal pulses per accepted instruction: exactly one. A dropped fetch produces none.
- Throughput with zero-wait memory and decode always accepting: one instruction per 3 cycles (LEERLAUF, ANFRAGE, HALTEN).

Decomposition:
- Shared package holds:
  - state enum (LEERLAUF, ANFRAGE, HALTEN, SPRUNG, ABWARTEN);
  - ADRESS_BREITE/DATEN_BREITE defaults;
  - constant for the all-ones address.
- Single module; no sub-module needed.
- The bench instantiates it together with the existing program counter.

Test Plan:
1. Reset, SpeicherBereit=1, BefehlAngenommen=1, memory[i]=0xA000_0000+i -> SpeicherAdresse 0,1,2,3; Befehl 0xA0000000.. in order; one TaktSignal per instruction; 3 cycles/instruction.
2. SpeicherBereit delayed 3 cycles at address 5 -> SpeicherLesen high 3 cycles with SpeicherAdresse=5 stable; single TaktSignal; PC=6 afterwards.
3. BefehlAngenommen=0 for 5 cycles -> Befehl/BefehlGueltig stable; no new SpeicherLesen; no extra TaktSignal.
4. Sprung, SprungZiel=0x100, in HALTEN -> BefehlGueltig=0 next cycle; NeuerPC=0xFF with SchreibSignal=TaktSignal=1 for one cycle; next SpeicherAdresse=0x100.
5. Sprung in ANFRAGE, SpeicherBereit 4 cycles later -> SpeicherLesen held on the old address, data dropped, BefehlGueltig stays 0; next fetch 0x100. Sprung to 0 -> NeuerPC=0x3FFFFFF, next fetch 0.
6. Reset asserted mid-ANFRAGE -> next cycle all outputs 0, state LEERLAUF; after release, fetch from address 0.
